// File: rtl/mfunc_apb_bridge.sv
// mfunc_apb_bridge
//   APB slave front end for the MFUNC register sub-blocks. Each transfer is
//   decoded into a one-hot write strobe and a shared sub-register address and
//   write-data bus. For reads, the selected sub-block's combinational read
//   data is captured and returned. Unmapped or unaligned accesses answer with
//   pslverr, and a saturating counter tallies them.
//   Every transfer takes three cycles: setup, one wait state, then completion.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   psel/penable/pwrite/paddr/pwdata   APB request
//   prdata/pready/pslverr              APB response (registered)
//   reg_wr_en         one-hot write strobe, one bit per sub-block, 1 cycle wide
//   sub_reg_addr      latched sub-register address (paddr[11:0])
//   reg_wr_data       latched write data
//   reg_rd_data_bus   sub-block read data, slice i = [32i+31:32i]
//   err_cnt           saturating count of error responses
module mfunc_apb_bridge #(
  parameter int NUM_SUB = 4,
  parameter int SUB_AW  = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [15:0]            paddr,
  input  logic [31:0]            pwdata,
  output logic [31:0]            prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic [NUM_SUB-1:0]     reg_wr_en,
  output logic [SUB_AW-1:0]      sub_reg_addr,
  output logic [31:0]            reg_wr_data,
  input  logic [NUM_SUB*32-1:0]  reg_rd_data_bus,
  output logic [7:0]             err_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, RESP = 2'd2} state_t;

  state_t r_state, w_state_nxt;

  logic [3:0]         r_idx, w_idx_nxt;
  logic               r_wr, w_wr_nxt;
  logic               r_err, w_err_nxt;
  logic [31:0]        r_prdata, w_prdata_nxt;
  logic               r_pready, w_pready_nxt;
  logic               r_pslverr, w_pslverr_nxt;
  logic [NUM_SUB-1:0] r_wr_en, w_wr_en_nxt;
  logic [SUB_AW-1:0]  r_addr, w_addr_nxt;
  logic [31:0]        r_wdata, w_wdata_nxt;
  logic [7:0]         r_err_cnt, w_err_cnt_nxt;

  logic               w_setup;
  logic               w_setup_err;
  logic [31:0]        w_rd_slice;

  // Only a setup phase (psel without penable) starts a transfer. A stray
  // access phase seen in IDLE is ignored.
  assign w_setup     = psel & ~penable;
  assign w_setup_err = ({1'b0, paddr[15:12]} >= 5'(NUM_SUB)) | (paddr[1:0] != 2'b00);

  // Read mux over the latched index. If the index is out of range, the mux
  // falls through to zero, but that case is an error anyway.
  always_comb begin
    w_rd_slice = '0;
    for (int i = 0; i < NUM_SUB; i++)
      if (r_idx == 4'(i)) w_rd_slice = reg_rd_data_bus[i*32 +: 32];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_setup) w_state_nxt = DECODE;
      DECODE:  w_state_nxt = psel ? RESP : IDLE;  // psel dropped => abort
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_idx_nxt     = r_idx;
    w_wr_nxt      = r_wr;
    w_err_nxt     = r_err;
    w_prdata_nxt  = r_prdata;
    w_pready_nxt  = r_pready;
    w_pslverr_nxt = r_pslverr;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_err_cnt_nxt = r_err_cnt;
    w_wr_en_nxt   = '0;  // the strobe only lives for the cycle after setup
    case (r_state)
      IDLE: if (w_setup) begin
        w_addr_nxt  = SUB_AW'(paddr[11:0]);
        w_wdata_nxt = pwdata;
        w_idx_nxt   = paddr[15:12];
        w_wr_nxt    = pwrite;
        w_err_nxt   = w_setup_err;
        for (int i = 0; i < NUM_SUB; i++)
          w_wr_en_nxt[i] = pwrite & ~w_setup_err & (paddr[15:12] == 4'(i));
      end
      DECODE: if (psel) begin
        w_prdata_nxt  = (!r_wr && !r_err) ? w_rd_slice : 32'h0;
        w_pslverr_nxt = r_err;
        w_pready_nxt  = 1'b1;
      end
      RESP: begin
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        if (r_pslverr && r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_wr_en   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_wr      <= w_wr_nxt;
      r_err     <= w_err_nxt;
      r_prdata  <= w_prdata_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign prdata       = r_prdata;
  assign pready       = r_pready;
  assign pslverr      = r_pslverr;
  assign reg_wr_en    = r_wr_en;
  assign sub_reg_addr = r_addr;
  assign reg_wr_data  = r_wdata;
  assign err_cnt      = r_err_cnt;

endmodule
